seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a 4-digit common-anode 7-segment display. One shared `decobin2seg` decoder drives all four digits, one digit at a time. The block:
- double-buffers a 16-bit hex value plus 4 decimal points;
- sequences the anodes with a guard interval between digits to suppress ghosting;
- applies optional leading-zero blanking.

It sits between the counter datapaths and the board display pins.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/decobin2seg.sv | 36 +++
 rtl/seg7_scan_ctrl.sv | 90 +++++++++
 tb/tb_seg7_scan_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 4-digit 7-segment scan controller:
// digit count and widths, anode constants, slot phases and the display payload.
package seg7_pkg;

  localparam int unsigned NDIG  = 4;
  localparam int unsigned DIG_W = 2;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned VAL_W = NDIG * NIB_W;

  localparam logic [NDIG-1:0] ANODE_OFF = 4'b1111;

  typedef enum logic {
    PH_GUARD = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

  typedef struct packed {
    logic [VAL_W-1:0] value;
    logic [NDIG-1:0]  dp;
  } disp_t;

  // Active-low anode pattern selecting a single digit.
  function automatic logic [NDIG-1:0] anode_onehot(input logic [DIG_W-1:0] dig);
    return ~(NDIG'(1) << dig);
  endfunction

endpackage

// File: rtl/decobin2seg.sv
// Hex-to-7-segment decoder for common-anode displays.
// saida = {dp, g, f, e, d, c, b, a}, all active-low.
module decobin2seg (
  input  logic [3:0] entrada,
  input  logic       dp,
  output logic [7:0] saida
);

  logic [6:0] w_seg;

  always_comb begin
    w_seg = 7'h00;
    case (entrada)
      4'h0: w_seg = 7'h3F;
      4'h1: w_seg = 7'h06;
      4'h2: w_seg = 7'h5B;
      4'h3: w_seg = 7'h4F;
      4'h4: w_seg = 7'h66;
      4'h5: w_seg = 7'h6D;
      4'h6: w_seg = 7'h7D;
      4'h7: w_seg = 7'h07;
      4'h8: w_seg = 7'h7F;
      4'h9: w_seg = 7'h6F;
      4'hA: w_seg = 7'h77;
      4'hB: w_seg = 7'h7C;
      4'hC: w_seg = 7'h39;
      4'hD: w_seg = 7'h5E;
      4'hE: w_seg = 7'h79;
      4'hF: w_seg = 7'h71;
      default: w_seg = 7'h00;
    endcase
  end

  assign saida = {~dp, ~w_seg};

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scan controller with a double-buffered
// value, guard interval between digits and optional leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned GUARD    = 500
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [VAL_W-1:0] value,
  input  logic [NDIG-1:0]  dp_in,
  input  logic             blank_lz,
  output logic [7:0]       segs,
  output logic [NDIG-1:0]  an,
  output logic             upd_pending,
  output logic             frame_sync
);

  localparam int unsigned     CNT_W    = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam phase_e          PH_RST   = (GUARD > 0) ? PH_GUARD : PH_DRIVE;

  logic [CNT_W-1:0] r_cnt;
  logic [DIG_W-1:0] r_dig;
  phase_e           r_phase;
  disp_t            r_shadow;
  disp_t            r_active;
  logic             r_pending;
  logic [NIB_W-1:0] r_nib;
  logic             r_dp;

  logic             w_slot_end;
  logic             w_frame_end;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [DIG_W-1:0] w_dig_nxt;
  disp_t            w_active_nxt;
  phase_e           w_phase_nxt;
  logic             w_blank;

  assign w_slot_end   = (r_cnt == CNT_LAST);
  assign w_frame_end  = w_slot_end && (r_dig == DIG_W'(NDIG - 1));
  assign w_cnt_nxt    = w_slot_end ? '0 : r_cnt + CNT_W'(1);
  assign w_dig_nxt    = w_slot_end ? r_dig + DIG_W'(1) : r_dig;
  // Shadow is promoted only at the frame boundary so a frame never mixes data.
  assign w_active_nxt = (w_frame_end && r_pending) ? r_shadow : r_active;
  assign w_phase_nxt  = (32'(w_cnt_nxt) < GUARD) ? PH_GUARD : PH_DRIVE;

  // Digit i>0 is dark when it and every more-significant nibble are zero.
  assign w_blank = blank_lz && (r_dig != '0) &&
                   ((r_active.value >> {r_dig, 2'b00}) == '0);

  assign an          = ((r_phase == PH_GUARD) || w_blank) ? ANODE_OFF : anode_onehot(r_dig);
  assign frame_sync  = w_frame_end;
  assign upd_pending = r_pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_dig     <= '0;
      r_phase   <= PH_RST;
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
      r_nib     <= '0;
      r_dp      <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_dig    <= w_dig_nxt;
      r_phase  <= w_phase_nxt;
      r_active <= w_active_nxt;
      if (load) begin
        r_shadow  <= '{value: value, dp: dp_in};
        r_pending <= 1'b1;
      end else if (w_frame_end) begin
        r_pending <= 1'b0;
      end
      r_nib <= w_active_nxt.value[{w_dig_nxt, 2'b00} +: NIB_W];
      r_dp  <= w_active_nxt.dp[w_dig_nxt];
    end
  end

  decobin2seg u_dec (
    .entrada (r_nib),
    .dp      (r_dp),
    .saida   (segs)
  );

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a frame-position model predicts every
// cycle's outputs, a monitor pops and compares them one cycle at a time.
module tb_seg7_scan_ctrl;

  localparam int P = 8;
  localparam int G = 2;
  localparam int FRAME = 4 * P;

  typedef struct {
    logic [3:0] an;
    logic [7:0] segs;
    logic       fs;
    logic       pend;
  } exp_t;

  localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [7:0]  segs;
  logic [3:0]  an;
  logic        upd_pending;
  logic        frame_sync;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  // Model state: position within the frame plus the two data buffers.
  int          m_t = 0;
  logic [15:0] m_sh_val = '0, m_act_val = '0;
  logic [3:0]  m_sh_dp = '0, m_act_dp = '0;
  logic        m_pend = 1'b0;
  logic        m_bl = 1'b0;

  seg7_scan_ctrl #(.PRESCALE(P), .GUARD(G)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .value       (value),
    .dp_in       (dp_in),
    .blank_lz    (blank_lz),
    .segs        (segs),
    .an          (an),
    .upd_pending (upd_pending),
    .frame_sync  (frame_sync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, expv);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int slot, c;
    logic [15:0] upper;
    logic [3:0] nib;
    slot  = m_t / P;
    c     = m_t % P;
    upper = m_act_val >> (4 * slot);
    nib   = upper[3:0];
    e.segs = {~m_act_dp[slot], ~SEG[nib]};
    if (c < G || (slot > 0 && m_bl && upper == 16'h0))
      e.an = 4'hF;
    else
      e.an = ~(4'(1) << slot);
    e.fs   = (m_t == FRAME - 1);
    e.pend = m_pend;
    return e;
  endfunction

  // Drive one cycle of inputs at the falling edge and queue the outcome of the next rising edge.
  task automatic step(input logic rst_i, input logic ld, input logic [15:0] v,
                      input logic [3:0] d, input logic bl);
    logic was_rst;
    @(negedge clk);
    was_rst  = reset;
    reset    = rst_i;
    load     = ld;
    value    = v;
    dp_in    = d;
    blank_lz = bl;
    m_bl     = bl;
    if (rst_i) begin
      m_t = 0; m_sh_val = '0; m_sh_dp = '0; m_act_val = '0; m_act_dp = '0; m_pend = 1'b0;
    end else begin
      if (m_t == FRAME - 1 && m_pend) begin
        m_act_val = m_sh_val;
        m_act_dp  = m_sh_dp;
      end
      if (ld) begin
        m_sh_val = v; m_sh_dp = d; m_pend = 1'b1;
      end else if (m_t == FRAME - 1) begin
        m_pend = 1'b0;
      end
      m_t = (m_t + 1) % FRAME;
    end
    exp_q.push_back(model_out());
    if (rst_i && !was_rst) begin
      #1;
      chk("rst_an_immediate", 32'(an), 32'hF);
      chk("rst_pend_immediate", 32'(upd_pending), 32'h0);
      chk("rst_fs_immediate", 32'(frame_sync), 32'h0);
    end
  endtask

  task automatic idle(input int n, input logic bl);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0, bl);
  endtask

  task automatic goto_t(input int target, input logic bl);
    while (m_t != target) step(1'b0, 1'b0, 16'h0, 4'h0, bl);
  endtask

  // Monitor: compares DUT outputs shortly after each rising edge against the queue head.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("an", 32'(an), 32'(e.an));
      chk("segs", 32'(segs), 32'(e.segs));
      chk("frame_sync", 32'(frame_sync), 32'(e.fs));
      chk("upd_pending", 32'(upd_pending), 32'(e.pend));
    end
  end

  initial begin
    // Reset held, then released with no load pending.
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    idle(2 * FRAME, 1'b0);

    // Mid-frame load shows in the following frame.
    goto_t(10, 1'b0);
    step(1'b0, 1'b1, 16'h12AF, 4'b0100, 1'b0);
    idle(2 * FRAME, 1'b0);

    // Two loads in one frame: only the second reaches the display.
    goto_t(5, 1'b0);
    step(1'b0, 1'b1, 16'h1111, 4'h0, 1'b0);
    goto_t(20, 1'b0);
    step(1'b0, 1'b1, 16'h2222, 4'h0, 1'b0);
    idle(2 * FRAME, 1'b0);

    // Load on the frame_sync cycle with older data still pending.
    goto_t(12, 1'b0);
    step(1'b0, 1'b1, 16'h3456, 4'b0001, 1'b0);
    goto_t(FRAME - 1, 1'b0);
    step(1'b0, 1'b1, 16'h789A, 4'b1000, 1'b0);
    idle(2 * FRAME, 1'b0);

    // Leading-zero blanking.
    step(1'b0, 1'b1, 16'h0040, 4'h0, 1'b1);
    idle(2 * FRAME, 1'b1);
    step(1'b0, 1'b1, 16'h0000, 4'h0, 1'b1);
    idle(2 * FRAME, 1'b1);
    step(1'b0, 1'b1, 16'h0305, 4'h0, 1'b1);
    idle(FRAME, 1'b1);
    idle(FRAME, 1'b0);

    // Reset during slot 2 with data pending.
    goto_t(3, 1'b0);
    step(1'b0, 1'b1, 16'hBEEF, 4'hF, 1'b0);
    goto_t(2 * P + 3, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    idle(FRAME + 4, 1'b0);

    // Randomized traffic.
    begin
      logic bl_r;
      bl_r = 1'b0;
      for (int i = 0; i < 800; i++) begin
        logic ld_r;
        if ($urandom_range(0, 49) == 0) bl_r = ~bl_r;
        ld_r = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 599) == 0)
          step(1'b1, 1'b0, 16'h0, 4'h0, bl_r);
        else
          step(1'b0, ld_r, 16'($urandom()) & ($urandom_range(0, 1) ? 16'hFFFF : 16'h00FF),
               4'($urandom()), bl_r);
      end
    end
    idle(4, 1'b0);

    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
